// File: rtl/lights_monitor.sv
// lights_monitor: checks the 3-bit traffic-light bus on the receiving end.
// It samples lights[2:0] on every clock and decodes the phase. It enforces
// the RED->GREEN->YELLOW->RED order and the per-phase minimum and maximum
// dwell. It counts completed cycles and latches the first violation.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | monitor disabled or waiting for the first RED
// RED    | red lamp observed, dwell counting
// GREEN  | green lamp observed, dwell counting
// YELLOW | yellow lamp observed, dwell counting
// FAULT  | protocol violation seen; bus ignored until Start drops
module lights_monitor #(
  parameter int G_MIN = 3,
  parameter int Y_MIN = 1,
  parameter int R_MIN = 3,
  parameter int T_MAX = 15,
  parameter int CW    = 4,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             Start,
  input  logic [2:0]       lights,
  output logic [1:0]       phase,
  output logic             fault,
  output logic             err_pulse,
  output logic [2:0]       err_code,
  output logic [CW-1:0]    dwell,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RED    = 3'd1;
  localparam logic [2:0] S_GREEN  = 3'd2;
  localparam logic [2:0] S_YELLOW = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_RED    = 2'd1;
  localparam logic [1:0] PH_GREEN  = 2'd2;
  localparam logic [1:0] PH_YELLOW = 2'd3;

  localparam logic [2:0] L_OFF    = 3'b000;
  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_GREEN  = 3'b001;

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_PATTERN = 3'd1;
  localparam logic [2:0] E_ORDER   = 3'd2;
  localparam logic [2:0] E_EARLY   = 3'd3;
  localparam logic [2:0] E_STAY    = 3'd4;
  localparam logic [2:0] E_START   = 3'd5;

  localparam logic [CW-1:0] C_TMAX = CW'(T_MAX);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [2:0]       r_state;
  logic [1:0]       r_phase;
  logic             r_fault;
  logic             r_err_pulse;
  logic [2:0]       r_err_code;
  logic [CW-1:0]    r_dwell;
  logic [CNT_W-1:0] r_cycles;

  logic             w_onehot;
  logic [2:0]       w_cur_lamp;
  logic [2:0]       w_succ_lamp;
  logic [2:0]       w_succ_state;
  logic [1:0]       w_succ_phase;
  logic [CW-1:0]    w_min;

  logic [2:0]       w_nxt_state;
  logic [1:0]       w_nxt_phase;
  logic [CW-1:0]    w_nxt_dwell;
  logic             w_err;
  logic [2:0]       w_code;
  logic             w_cyc_inc;

  assign w_onehot = (lights == L_RED) || (lights == L_YELLOW) || (lights == L_GREEN);

  // Per-phase lookup: the lamp we expect now, its legal successor and the minimum dwell.
  always_comb begin
    w_cur_lamp   = L_OFF;
    w_succ_lamp  = L_OFF;
    w_succ_state = S_IDLE;
    w_succ_phase = PH_IDLE;
    w_min        = '0;
    case (r_state)
      S_RED: begin
        w_cur_lamp   = L_RED;
        w_succ_lamp  = L_GREEN;
        w_succ_state = S_GREEN;
        w_succ_phase = PH_GREEN;
        w_min        = CW'(R_MIN);
      end
      S_GREEN: begin
        w_cur_lamp   = L_GREEN;
        w_succ_lamp  = L_YELLOW;
        w_succ_state = S_YELLOW;
        w_succ_phase = PH_YELLOW;
        w_min        = CW'(G_MIN);
      end
      S_YELLOW: begin
        w_cur_lamp   = L_YELLOW;
        w_succ_lamp  = L_RED;
        w_succ_state = S_RED;
        w_succ_phase = PH_RED;
        w_min        = CW'(Y_MIN);
      end
      default: begin
        w_cur_lamp   = L_OFF;
        w_succ_lamp  = L_OFF;
        w_succ_state = S_IDLE;
        w_succ_phase = PH_IDLE;
        w_min        = '0;
      end
    endcase
  end

  // Next-state decode; within an active phase the checks run in priority order.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_phase = r_phase;
    w_nxt_dwell = r_dwell;
    w_err       = 1'b0;
    w_code      = E_NONE;
    w_cyc_inc   = 1'b0;
    if (!Start) begin
      w_nxt_state = S_IDLE;
      w_nxt_phase = PH_IDLE;
      w_nxt_dwell = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (lights == L_RED) begin
            w_nxt_state = S_RED;
            w_nxt_phase = PH_RED;
            w_nxt_dwell = C_ONE;
          end else if (lights != L_OFF) begin
            w_err  = 1'b1;
            w_code = E_START;
          end
        end
        S_RED, S_GREEN, S_YELLOW: begin
          if (!w_onehot) begin
            w_err  = 1'b1;
            w_code = E_PATTERN;
          end else if (lights == w_cur_lamp) begin
            if (r_dwell == C_TMAX) begin
              w_err  = 1'b1;
              w_code = E_STAY;
            end else begin
              w_nxt_dwell = r_dwell + C_ONE;
            end
          end else if (lights != w_succ_lamp) begin
            w_err  = 1'b1;
            w_code = E_ORDER;
          end else if (r_dwell < w_min) begin
            w_err  = 1'b1;
            w_code = E_EARLY;
          end else begin
            w_nxt_state = w_succ_state;
            w_nxt_phase = w_succ_phase;
            w_nxt_dwell = C_ONE;
            w_cyc_inc   = (r_state == S_YELLOW);
          end
        end
        S_FAULT: begin
          w_nxt_state = S_FAULT;
        end
        default: begin
          w_nxt_state = S_IDLE;
          w_nxt_phase = PH_IDLE;
          w_nxt_dwell = '0;
        end
      endcase
      // An error freezes phase and dwell; only the state moves to FAULT.
      if (w_err) begin
        w_nxt_state = S_FAULT;
        w_nxt_phase = r_phase;
        w_nxt_dwell = r_dwell;
      end
    end
  end

  // Register state and outputs; err_code keeps the first error, cycles wraps freely.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state     <= S_IDLE;
      r_phase     <= PH_IDLE;
      r_fault     <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_code  <= E_NONE;
      r_dwell     <= '0;
      r_cycles    <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_phase     <= w_nxt_phase;
      r_fault     <= (w_nxt_state == S_FAULT);
      r_err_pulse <= w_err;
      r_dwell     <= w_nxt_dwell;
      if (w_err && (r_err_code == E_NONE)) begin
        r_err_code <= w_code;
      end
      if (w_cyc_inc) begin
        r_cycles <= r_cycles + CNT_W'(1);
      end
    end
  end

  assign phase     = r_phase;
  assign fault     = r_fault;
  assign err_pulse = r_err_pulse;
  assign err_code  = r_err_code;
  assign dwell     = r_dwell;
  assign cycles    = r_cycles;

endmodule

// File: tb/tb_lights_monitor.sv
// Directed bench for lights_monitor: a vector table covering the legal cycle
// and the main error paths, followed by hand-written multi-cycle sequences.
module tb_lights_monitor;

  logic       Clk;
  logic       nReset;
  logic       Start;
  logic [2:0] lights;
  logic [1:0] phase;
  logic       fault;
  logic       err_pulse;
  logic [2:0] err_code;
  logic [3:0] dwell;
  logic [7:0] cycles;

  int n_cmp = 0;
  int n_err = 0;

  lights_monitor dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .Start     (Start),
    .lights    (lights),
    .phase     (phase),
    .fault     (fault),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .dwell     (dwell),
    .cycles    (cycles)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       start;
    logic [2:0] lt;
    logic [1:0] ph;
    logic       flt;
    logic       pls;
    logic [2:0] code;
    logic [3:0] dw;
    logic [7:0] cy;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] ph, input logic flt,
                         input logic pls, input logic [2:0] code, input logic [3:0] dw,
                         input logic [7:0] cy);
    chk({tag, ".phase"}, 16'(phase), 16'(ph));
    chk({tag, ".fault"}, 16'(fault), 16'(flt));
    chk({tag, ".err_pulse"}, 16'(err_pulse), 16'(pls));
    chk({tag, ".err_code"}, 16'(err_code), 16'(code));
    chk({tag, ".dwell"}, 16'(dwell), 16'(dw));
    chk({tag, ".cycles"}, 16'(cycles), 16'(cy));
  endtask

  // Drive on the falling edge, then sample 1 ns after the next rising edge.
  task automatic apply(input logic s, input logic [2:0] l);
    @(negedge Clk);
    Start  = s;
    lights = l;
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_n(input logic s, input logic [2:0] l, input int n);
    for (int k = 0; k < n; k++) apply(s, l);
  endtask

  task automatic do_reset(input string tag);
    @(negedge Clk);
    Start  = 1'b0;
    lights = 3'b000;
    nReset = 1'b0;
    #1;
    chk_all(tag, 2'd0, 1'b0, 1'b0, 3'd0, 4'd0, 8'd0);
    #11;
    nReset = 1'b1;
  endtask

  task automatic set_vec(input int i, input logic s, input logic [2:0] l, input logic [1:0] ph,
                         input logic flt, input logic pls, input logic [2:0] code,
                         input logic [3:0] dw, input logic [7:0] cy);
    vecs[i].start = s;
    vecs[i].lt    = l;
    vecs[i].ph    = ph;
    vecs[i].flt   = flt;
    vecs[i].pls   = pls;
    vecs[i].code  = code;
    vecs[i].dw    = dw;
    vecs[i].cy    = cy;
  endtask

  logic [7:0] exp_cy;

  initial begin
    //           start lights  ph flt pls code dw  cy
    set_vec( 0, 1, 3'b000, 0, 0, 0, 0, 0, 0);
    set_vec( 1, 1, 3'b100, 1, 0, 0, 0, 1, 0);
    set_vec( 2, 1, 3'b100, 1, 0, 0, 0, 2, 0);
    set_vec( 3, 1, 3'b100, 1, 0, 0, 0, 3, 0);
    set_vec( 4, 1, 3'b001, 2, 0, 0, 0, 1, 0);
    set_vec( 5, 1, 3'b001, 2, 0, 0, 0, 2, 0);
    set_vec( 6, 1, 3'b001, 2, 0, 0, 0, 3, 0);
    set_vec( 7, 1, 3'b010, 3, 0, 0, 0, 1, 0);
    set_vec( 8, 1, 3'b100, 1, 0, 0, 0, 1, 1);
    set_vec( 9, 1, 3'b100, 1, 0, 0, 0, 2, 1);
    set_vec(10, 1, 3'b100, 1, 0, 0, 0, 3, 1);
    set_vec(11, 1, 3'b001, 2, 0, 0, 0, 1, 1);
    set_vec(12, 1, 3'b001, 2, 0, 0, 0, 2, 1);
    set_vec(13, 1, 3'b100, 2, 1, 1, 2, 2, 1);  // GREEN->RED illegal order
    set_vec(14, 1, 3'b111, 2, 1, 0, 2, 2, 1);  // FAULT ignores bus
    set_vec(15, 0, 3'b000, 0, 0, 0, 2, 0, 1);  // Start=0 clears fault
    set_vec(16, 1, 3'b010, 0, 1, 1, 2, 0, 1);  // illegal start, code stays 2
    set_vec(17, 0, 3'b000, 0, 0, 0, 2, 0, 1);
    set_vec(18, 1, 3'b100, 1, 0, 0, 2, 1, 1);
    set_vec(19, 1, 3'b000, 1, 1, 1, 2, 1, 1);  // lamps dark mid-phase

    // Power-on reset held 12 ns, all outputs at zero throughout.
    nReset = 1'b0;
    Start  = 1'b0;
    lights = 3'b000;
    #1;
    chk_all("por_a", 2'd0, 1'b0, 1'b0, 3'd0, 4'd0, 8'd0);
    #11;
    nReset = 1'b1;
    apply(1'b0, 3'b000);
    chk_all("por_b", 2'd0, 1'b0, 1'b0, 3'd0, 4'd0, 8'd0);

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i].start, vecs[i].lt);
      chk_all($sformatf("vec%0d", i), vecs[i].ph, vecs[i].flt, vecs[i].pls,
              vecs[i].code, vecs[i].dw, vecs[i].cy);
    end

    // Early GREEN exit
    do_reset("rst_early");
    apply_n(1'b1, 3'b100, 3);
    apply_n(1'b1, 3'b001, 2);
    chk_all("early_pre", 2'd2, 1'b0, 1'b0, 3'd0, 4'd2, 8'd0);
    apply(1'b1, 3'b010);
    chk_all("early_err", 2'd2, 1'b1, 1'b1, 3'd3, 4'd2, 8'd0);
    apply(1'b1, 3'b010);
    chk_all("early_hold", 2'd2, 1'b1, 1'b0, 3'd3, 4'd2, 8'd0);

    // Early RED exit
    do_reset("rst_early_r");
    apply_n(1'b1, 3'b100, 2);
    apply(1'b1, 3'b001);
    chk_all("early_red", 2'd1, 1'b1, 1'b1, 3'd3, 4'd2, 8'd0);

    // Bad pattern, then restart on GREEN; the first code must win
    do_reset("rst_pat");
    apply_n(1'b1, 3'b100, 3);
    apply(1'b1, 3'b001);
    apply(1'b1, 3'b011);
    chk_all("pat_err", 2'd2, 1'b1, 1'b1, 3'd1, 4'd1, 8'd0);
    apply(1'b0, 3'b000);
    chk_all("pat_stop", 2'd0, 1'b0, 1'b0, 3'd1, 4'd0, 8'd0);
    apply(1'b1, 3'b001);
    chk_all("pat_restart", 2'd0, 1'b1, 1'b1, 3'd1, 4'd0, 8'd0);

    // Overstay: RED for 16 samples
    do_reset("rst_stay");
    for (int i = 1; i <= 15; i++) begin
      apply(1'b1, 3'b100);
      chk("stay_dwell", 16'(dwell), 16'(i));
      chk("stay_fault", 16'(fault), 16'd0);
    end
    apply(1'b1, 3'b100);
    chk_all("stay_err", 2'd1, 1'b1, 1'b1, 3'd4, 4'd15, 8'd0);

    // Async reset pulsed between edges while in YELLOW
    do_reset("rst_async");
    apply_n(1'b1, 3'b100, 3);
    apply_n(1'b1, 3'b001, 3);
    apply(1'b1, 3'b010);
    chk_all("async_pre", 2'd3, 1'b0, 1'b0, 3'd0, 4'd1, 8'd0);
    @(negedge Clk);
    #1;
    nReset = 1'b0;
    lights = 3'b100;
    #1;
    chk_all("async_now", 2'd0, 1'b0, 1'b0, 3'd0, 4'd0, 8'd0);
    #1;
    nReset = 1'b1;
    @(posedge Clk);
    #1;
    chk_all("async_after", 2'd1, 1'b0, 1'b0, 3'd0, 4'd1, 8'd0);

    // Cycle counter wraps at 256 without any error
    do_reset("rst_wrap");
    apply_n(1'b1, 3'b100, 3);
    exp_cy = 8'd0;
    for (int k = 0; k < 256; k++) begin
      apply_n(1'b1, 3'b001, 3);
      apply(1'b1, 3'b010);
      apply_n(1'b1, 3'b100, 3);
      exp_cy = exp_cy + 8'd1;
      if (k == 254 || k == 255) begin
        chk_all($sformatf("wrap%0d", k), 2'd1, 1'b0, 1'b0, 3'd0, 4'd3, exp_cy);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
